// File: rtl/pipe_stage_elastic_pkg.sv
// Shared occupancy-state encoding for the elastic pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with a variable increment, cleared only by the async reset.
module pipe_sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [INC_W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + (W+1)'(b);
        return sum[W] ? {W{1'b1}} : sum[W-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else        count <= sat_add(count, inc);
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with flush and optional 2-entry skid buffer.
// Optional statistics counters (stall_cnt, drop_cnt) are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}},
    parameter int               SKID        = 1
`ifdef PIPE_STAGE_STATS_EN
    , parameter int             CNT_W       = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_STATS_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] drop_cnt
`endif
);

    pipe_state_t      state_p0;
    logic [WIDTH-1:0] main_p0;
    logic [WIDTH-1:0] skid_p0;
    logic             rdy_p0;
    logic             acc;
    logic             drn;

    assign out_valid = (state_p0 != ST_EMPTY);
    assign occupancy = state_p0;
    assign out_data  = main_p0;
    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;

    // With the skid buffer the ready is a flop; without it, ready looks through to out_ready.
    assign in_ready = (SKID != 0) ? rdy_p0 : (reset & (~out_valid | out_ready));

    // Stage p0: entry storage and occupancy state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0 <= ST_EMPTY;
            main_p0  <= FLUSH_VALUE;
            skid_p0  <= FLUSH_VALUE;
            rdy_p0   <= 1'b0;
        end else if (flush) begin
            state_p0 <= ST_EMPTY;
            main_p0  <= FLUSH_VALUE;
            skid_p0  <= FLUSH_VALUE;
            rdy_p0   <= 1'b1;
        end else begin
            rdy_p0 <= 1'b1;
            case (state_p0)
                ST_EMPTY: begin
                    if (acc) begin
                        state_p0 <= ST_ONE;
                        main_p0  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (acc && drn) begin
                        main_p0 <= in_data;
                    end else if (acc && (SKID != 0)) begin
                        state_p0 <= ST_TWO;
                        skid_p0  <= in_data;
                        rdy_p0   <= 1'b0;
                    end else if (drn) begin
                        state_p0 <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drn) begin
                        state_p0 <= ST_ONE;
                        main_p0  <= skid_p0;
                    end else begin
                        rdy_p0 <= 1'b0;
                    end
                end
                default: state_p0 <= ST_EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [1:0] stall_inc;
    logic [1:0] drop_inc;

    assign stall_inc = {1'b0, out_valid & ~out_ready};
    assign drop_inc  = flush ? (occupancy + {1'b0, acc}) : 2'd0;

    pipe_sat_counter #(.W(CNT_W), .INC_W(2)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.W(CNT_W), .INC_W(2)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .count (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomised bench for pipe_stage_elastic: one SKID=1 and one SKID=0 instance against a queue model.
module tb_pipe_stage_elastic;

    localparam int          W  = 8;
    localparam logic [W-1:0] FV = 8'h00;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;

    logic         ov  [2];
    logic         ir  [2];
    logic [W-1:0] od  [2];
    logic [1:0]   occ [2];
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]  stall_c [2];
    logic [15:0]  drop_c  [2];
`endif

    int vectors = 0;
    int miscompares = 0;

    // reference model: per instance a FIFO of at most two beats
    logic [W-1:0] mq [2][2];
    int           mcnt   [2];
    logic [W-1:0] mstale [2];
    bit           mrdy   [2];
    int           mstall [2];
    int           mdrop  [2];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(W), .FLUSH_VALUE(FV), .SKID(1)) u_skid1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (ir[1]),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (ov[1]),
        .out_ready (out_ready),
        .out_data  (od[1]),
        .occupancy (occ[1])
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt (stall_c[1])
        , .drop_cnt  (drop_c[1])
`endif
    );

    pipe_stage_elastic #(.WIDTH(W), .FLUSH_VALUE(FV), .SKID(0)) u_skid0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (ir[0]),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (ov[0]),
        .out_ready (out_ready),
        .out_data  (od[0]),
        .occupancy (occ[0])
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt (stall_c[0])
        , .drop_cnt  (drop_c[0])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle on the falling edge, compare against the model, then advance the model.
    task automatic step(input bit rs, input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        bit rdy, acc, drn;
        @(negedge clk);
        reset = rs; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        if (!rs) begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k] = 0; mstale[k] = FV; mrdy[k] = 1'b0; mstall[k] = 0; mdrop[k] = 0;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy = (k == 1) ? mrdy[k] : (rs && (mcnt[k] == 0 || ordy));
            chk($sformatf("valid%0d", k), 32'(ov[k]), 32'(mcnt[k] != 0));
            chk($sformatf("occ%0d", k), 32'(occ[k]), 32'(mcnt[k]));
            chk($sformatf("data%0d", k), 32'(od[k]), 32'((mcnt[k] != 0) ? mq[k][0] : mstale[k]));
            chk($sformatf("ready%0d", k), 32'(ir[k]), 32'(rdy));
`ifdef PIPE_STAGE_STATS_EN
            chk($sformatf("stall%0d", k), 32'(stall_c[k]), 32'(mstall[k]));
            chk($sformatf("drop%0d", k), 32'(drop_c[k]), 32'(mdrop[k]));
`endif
            if (rs) begin
                acc = iv && rdy;
                drn = (mcnt[k] != 0) && ordy;
                if (mcnt[k] != 0 && !ordy) mstall[k]++;
                if (fl) begin
                    mdrop[k] += mcnt[k] + int'(acc);
                    mcnt[k] = 0; mstale[k] = FV; mrdy[k] = 1'b1;
                end else begin
                    if (drn) begin
                        mstale[k] = mq[k][0];
                        mq[k][0] = mq[k][1];
                        mcnt[k]--;
                    end
                    if (acc) begin
                        mq[k][mcnt[k]] = d;
                        mcnt[k]++;
                    end
                    mrdy[k] = (mcnt[k] < 2);
                end
            end
        end
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, $urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 15) == 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mstale[k] = FV; mrdy[k] = 1'b0; mstall[k] = 0; mdrop[k] = 0;
            mq[k][0] = FV; mq[k][1] = FV;
        end

        // reset held for three cycles, then released
        repeat (3) step(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
        chk("rst_data", 32'(od[1]), 32'(FV));
        chk("rst_ready", 32'(ir[1]), 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("first_ready", 32'(ir[1]), 32'd1);

        // back-to-back streaming
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
        chk("stream_first", 32'(od[1]), 32'h11);
        step(1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_last", 32'(od[1]), 32'h33);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // stall fills the skid entry
        step(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("fill_occ", 32'(occ[1]), 32'd2);
        chk("fill_ready", 32'(ir[1]), 32'd0);
        chk("fill_data", 32'(od[1]), 32'hA1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_second", 32'(od[1]), 32'hA2);
        chk("drain_ready", 32'(ir[1]), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // flush while two beats are held
        step(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_occ", 32'(occ[1]), 32'd0);
        chk("flush_data", 32'(od[1]), 32'(FV));

        // single-entry pass-through under stall
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s0_stall_ready", 32'(ir[0]), 32'd0);
        step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("s0_pass_data", 32'(od[0]), 32'h5A);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);

        rand_steps(600);

        // asynchronous reset while two beats are held
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_arst_occ", 32'(occ[1]), 32'd2);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("arst_valid", 32'(ov[1]), 32'd0);
        chk("arst_occ", 32'(occ[1]), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_arst_valid", 32'(ov[1]), 32'd0);
        rand_steps(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
